muldiv_iter: RTL and testbench

//  Parametrised iterative multiply/divide unit for the EX stage; replaces the fixed 32-bit mul/div pair

---
 rtl/muldiv_if.sv | 30 +++
 rtl/muldiv_iter.sv | 174 +++++++++++++++++
 tb/tb_muldiv_iter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_if
// Purpose  : Handshake and operand/result bundle between EX stage and muldiv_iter.
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [1:0]           op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 flush;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   hilo_o;
  logic                 div_zero;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hilo_o, div_zero
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hilo_o, div_zero
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_iter
// Purpose  : Iterative radix-2 MULT/MULTU/DIV/DIVU unit producing {HI,LO}.
//            Define MULDIV_DIV_ZERO_EN for the early-exit divide-by-zero path.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic                 r_signed;
  logic                 r_isdiv;
  logic                 r_sa;
  logic                 r_sb;
  logic                 r_bzero;
  logic [WIDTH-1:0]     r_a_raw;
  logic [WIDTH-1:0]     r_oper;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_hilo;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_signed;
  logic                 w_neg_a;
  logic                 w_neg_b;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic                 w_bzero;
  logic                 w_accept;
  logic [WIDTH-1:0]     w_hi;
  logic [WIDTH-1:0]     w_lo;
  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH:0]       w_add;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_rsh;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quot;
  logic [WIDTH-1:0]     w_rem;
  logic [2*WIDTH-1:0]   w_result;

  assign w_signed = ~bus.op[0];
  assign w_neg_a  = w_signed & bus.a[WIDTH-1];
  assign w_neg_b  = w_signed & bus.b[WIDTH-1];
  assign w_abs_a  = w_neg_a ? -bus.a : bus.a;
  assign w_abs_b  = w_neg_b ? -bus.b : bus.b;
  assign w_bzero  = (bus.b == '0);
  assign w_accept = bus.start & ~r_busy & ~bus.flush &
                    ((r_state == S_IDLE) | (r_state == S_DONE));

  // Multiply: acc = {partial, multiplier}, add-then-shift-right each step.
  assign w_hi       = r_acc[2*WIDTH-1:WIDTH];
  assign w_lo       = r_acc[WIDTH-1:0];
  assign w_addend   = w_lo[0] ? r_oper : '0;
  assign w_add      = {1'b0, w_hi} + {1'b0, w_addend};
  assign w_mul_next = {w_add, w_lo[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}, shift-left then trial subtract.
  assign w_rsh      = {w_hi, w_lo[WIDTH-1]};
  assign w_diff     = w_rsh - {1'b0, r_oper};
  assign w_div_next = w_diff[WIDTH] ? {w_rsh[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b1};

  assign w_prod   = (r_signed & (r_sa ^ r_sb)) ? -r_acc : r_acc;
  assign w_quot   = (r_signed & (r_sa ^ r_sb)) ? -w_lo  : w_lo;
  assign w_rem    = (r_signed & r_sa)          ? -w_hi  : w_hi;
  assign w_result = (r_isdiv & r_bzero) ? {r_a_raw, {WIDTH{1'b1}}} :
                    r_isdiv             ? {w_rem, w_quot} : w_prod;

`ifdef MULDIV_DIV_ZERO_EN
  logic r_divz;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_signed <= 1'b0;
      r_isdiv  <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_bzero  <= 1'b0;
      r_a_raw  <= '0;
      r_oper   <= '0;
      r_acc    <= '0;
      r_hilo   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef MULDIV_DIV_ZERO_EN
      r_divz   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (bus.flush) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (w_accept) begin
              r_signed <= w_signed;
              r_isdiv  <= bus.op[1];
              r_sa     <= w_neg_a;
              r_sb     <= w_neg_b;
              r_bzero  <= w_bzero;
              r_a_raw  <= bus.a;
              r_oper   <= bus.op[1] ? w_abs_b : w_abs_a;
              r_acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? w_abs_a : w_abs_b)};
              r_cnt    <= CW'(WIDTH - 1);
`ifdef MULDIV_DIV_ZERO_EN
              r_divz   <= 1'b0;
              if (bus.op[1] && w_bzero) begin
                r_hilo  <= {bus.a, {WIDTH{1'b1}}};
                r_divz  <= 1'b1;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_busy  <= 1'b1;
                r_state <= S_CALC;
              end
`else
              r_busy   <= 1'b1;
              r_state  <= S_CALC;
`endif
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_CALC: begin
            r_acc <= r_isdiv ? w_div_next : w_mul_next;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
              r_state <= S_FIX;
            end
          end
          S_FIX: begin
            r_hilo  <= w_result;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.hilo_o = r_hilo;
`ifdef MULDIV_DIV_ZERO_EN
  assign bus.div_zero = r_divz;
`else
  assign bus.div_zero = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_iter
// Purpose  : Directed self-checking bench for muldiv_iter at WIDTH=32
//            (expectations follow MULDIV_DIV_ZERO_EN when defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_iter;
  localparam int W = 32;

`ifdef MULDIV_DIV_ZERO_EN
  localparam int          DZ_LAT = 1;
  localparam logic [63:0] DZ_FLAG = 64'd1;
`else
  localparam int          DZ_LAT = 34;
  localparam logic [63:0] DZ_FLAG = 64'd0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_iter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle 1 of an operation; returns the cycle done is seen (or -1).
  task automatic wait_done(output int lat, output logic busy_all);
    lat      = -1;
    busy_all = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      if (bus.done) begin
        lat = c;
        break;
      end
      busy_all = busy_all & bus.busy;
      tick();
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic busy_all);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.op    = 2'($urandom);
    wait_done(lat, busy_all);
  endtask

  int   lat;
  logic ball;
  logic seen_done;

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    tick();
    tick();
    chk("rst_busy", bus.busy, 64'd0);
    chk("rst_done", bus.done, 64'd0);
    chk("rst_hilo", bus.hilo_o, 64'd0);
    chk("rst_divz", bus.div_zero, 64'd0);
    rst = 1'b0;
    tick();

    // Largest unsigned product, full latency and busy profile
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, ball);
    chk("multu_max_lat", lat, 64'd34);
    chk("multu_max_hilo", bus.hilo_o, 64'hFFFF_FFFE_0000_0001);
    chk("multu_busy_1_33", ball, 64'd1);
    chk("multu_busy_done", bus.busy, 64'd0);
    tick();
    chk("done_one_cycle", bus.done, 64'd0);

    do_op(2'b00, 32'hFFFF_FFFD, 32'd7, lat, ball);
    chk("mult_neg_lat", lat, 64'd34);
    chk("mult_neg_hilo", bus.hilo_o, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, lat, ball);
    chk("mult_minmin", bus.hilo_o, 64'h4000_0000_0000_0000);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, ball);
    chk("div_m7_2", bus.hilo_o, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(2'b10, 32'd7, 32'hFFFF_FFFE, lat, ball);
    chk("div_7_m2", bus.hilo_o, 64'h0000_0001_FFFF_FFFD);
    do_op(2'b11, 32'd100, 32'd7, lat, ball);
    chk("divu_100_7", bus.hilo_o, 64'h0000_0002_0000_000E);

    // Signed overflow wraps; unsigned view of the same bits
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, ball);
    chk("div_ovf", bus.hilo_o, 64'h0000_0000_8000_0000);
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat, ball);
    chk("divu_big", bus.hilo_o, 64'h8000_0000_0000_0000);

    // Divide by zero
    do_op(2'b11, 32'd100, 32'd0, lat, ball);
    chk("divu0_lat", lat, 64'(DZ_LAT));
    chk("divu0_hilo", bus.hilo_o, 64'h0000_0064_FFFF_FFFF);
    chk("divu0_flag", bus.div_zero, DZ_FLAG);
    do_op(2'b10, 32'hFFFF_FFFB, 32'd0, lat, ball);
    chk("div0_hilo", bus.hilo_o, 64'hFFFF_FFFB_FFFF_FFFF);
    chk("div0_flag", bus.div_zero, DZ_FLAG);
    do_op(2'b01, 32'd3, 32'd4, lat, ball);
    chk("multu_3_4", bus.hilo_o, 64'd12);
    chk("divz_cleared", bus.div_zero, 64'd0);
    tick();

    // Flush mid-operation with an ignored start at cycle 5
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd5; bus.b = 32'd6;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd9; bus.b = 32'd9;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    chk("flush_busy_c10", bus.busy, 64'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_busy_c11", bus.busy, 64'd0);
    chk("flush_done_c11", bus.done, 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen_done = seen_done | bus.done;
      tick();
    end
    chk("flush_no_done", seen_done, 64'd0);
    chk("flush_hilo_kept", bus.hilo_o, 64'd12);

    // Flush beats a same-cycle start
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b01; bus.a = 32'd2; bus.b = 32'd2;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush_vs_start", bus.busy, 64'd0);

    // Reset mid-operation
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd5; bus.b = 32'd6;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", bus.busy, 64'd0);
    chk("rst_mid_hilo", bus.hilo_o, 64'd0);
    tick();

    // Back-to-back: second start in the DONE cycle of the first
    do_op(2'b01, 32'd5, 32'd6, lat, ball);
    chk("b2b_op1", bus.hilo_o, 64'd30);
    bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd100; bus.b = 32'd7;
    tick();
    bus.start = 1'b0;
    chk("b2b_op1_held", bus.hilo_o, 64'd30);
    chk("b2b_op2_busy", bus.busy, 64'd1);
    wait_done(lat, ball);
    chk("b2b_op2_lat", lat, 64'd34);
    chk("b2b_op2_hilo", bus.hilo_o, 64'h0000_0002_0000_000E);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
